// File: rtl/forest_loader.sv
// forest_loader
// Stream-side driver for the random-forest engine. It takes one job from the
// cfg_* request, pulls 64-bit words from the in_* stream and steers them to the
// engine. Tree words go to the load_trees port (tree-major order). Feature-pair
// words go to the load_features port (N_FEATURE/2 words per sample). Then it
// pulses a run with start/done and returns each prediction on the out_* stream.
//
// Ports:
//   clk, rst                    clock, async active-high reset
//   cfg_valid/cfg_ready         job request (load_model flag, sample count)
//   in_valid/in_ready/in_data   64-bit input word stream
//   load_trees/n_tree/n_node/tree_nodes       tree write port
//   load_features/n_feature/features2         feature-pair write port
//   start/done/prediction       engine run handshake
//   out_valid/out_ready/out_data  prediction stream
//   job_done                    one-cycle pulse at end of job
//   timeout_err                 sticky watchdog flag (FOREST_LOADER_TIMEOUT_EN only)
//
// Build option: define FOREST_LOADER_TIMEOUT_EN to add the RUN watchdog.
module forest_loader #(
    parameter int N_TREES          = 16,
    parameter int N_NODE_AND_LEAFS = 256,
    parameter int N_FEATURE        = 32,
    parameter int TIMEOUT_CYCLES   = 4096
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                cfg_valid,
    input  logic                                cfg_load_model,
    input  logic [15:0]                         cfg_n_samples,
    output logic                                cfg_ready,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [63:0]                         in_data,
    output logic                                load_trees,
    output logic [$clog2(N_TREES)-1:0]          n_tree,
    output logic [$clog2(N_NODE_AND_LEAFS)-1:0] n_node,
    output logic [63:0]                         tree_nodes,
    output logic                                load_features,
    output logic [31:0]                         n_feature,
    output logic [63:0]                         features2,
    output logic                                start,
    input  logic                                done,
    input  logic signed [31:0]                  prediction,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [31:0]                         out_data,
    output logic                                job_done
`ifdef FOREST_LOADER_TIMEOUT_EN
    ,
    output logic                                timeout_err
`endif
);

    localparam int TW = $clog2(N_TREES);
    localparam int NW = $clog2(N_NODE_AND_LEAFS);
    localparam logic [TW-1:0] LAST_TREE = TW'(N_TREES - 1);
    localparam logic [NW-1:0] LAST_NODE = NW'(N_NODE_AND_LEAFS - 1);
    localparam logic [31:0]   LAST_FEAT = 32'(N_FEATURE - 2);

    typedef enum logic [2:0] {IDLE, LOAD_TREES, LOAD_FEAT, RUN, EMIT, FINISH} state_t;

    state_t        state;
    logic [15:0]   n_samples_q;
    logic [15:0]   sample_cnt;
    logic [TW-1:0] tree_cnt;
    logic [NW-1:0] node_cnt;
    logic [31:0]   feat_idx;
    logic          done_low_seen;   // done seen low since start rose
`ifdef FOREST_LOADER_TIMEOUT_EN
    localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TOW-1:0] to_cnt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            n_samples_q   <= '0;
            sample_cnt    <= '0;
            tree_cnt      <= '0;
            node_cnt      <= '0;
            feat_idx      <= '0;
            done_low_seen <= 1'b0;
            cfg_ready     <= 1'b1;
            in_ready      <= 1'b0;
            load_trees    <= 1'b0;
            n_tree        <= '0;
            n_node        <= '0;
            tree_nodes    <= '0;
            load_features <= 1'b0;
            n_feature     <= '0;
            features2     <= '0;
            start         <= 1'b0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            job_done      <= 1'b0;
`ifdef FOREST_LOADER_TIMEOUT_EN
            to_cnt        <= '0;
            timeout_err   <= 1'b0;
`endif
        end else begin
            load_trees    <= 1'b0;
            load_features <= 1'b0;
            job_done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        n_samples_q <= cfg_n_samples;
                        sample_cnt  <= '0;
                        tree_cnt    <= '0;
                        node_cnt    <= '0;
                        feat_idx    <= '0;
                        cfg_ready   <= 1'b0;
`ifdef FOREST_LOADER_TIMEOUT_EN
                        timeout_err <= 1'b0;
`endif
                        if (cfg_load_model) begin
                            state    <= LOAD_TREES;
                            in_ready <= 1'b1;
                        end else if (cfg_n_samples != 16'd0) begin
                            state    <= LOAD_FEAT;
                            in_ready <= 1'b1;
                        end else begin
                            state    <= FINISH;
                            job_done <= 1'b1;
                        end
                    end
                end
                LOAD_TREES: begin
                    if (in_valid && in_ready) begin
                        load_trees <= 1'b1;
                        tree_nodes <= in_data;
                        n_tree     <= tree_cnt;
                        n_node     <= node_cnt;
                        if (node_cnt == LAST_NODE) begin
                            node_cnt <= '0;
                            if (tree_cnt == LAST_TREE) begin
                                tree_cnt <= '0;
                                if (n_samples_q == 16'd0) begin
                                    state    <= FINISH;
                                    in_ready <= 1'b0;
                                    job_done <= 1'b1;
                                end else begin
                                    state    <= LOAD_FEAT;
                                end
                            end else begin
                                tree_cnt <= tree_cnt + 1'b1;
                            end
                        end else begin
                            node_cnt <= node_cnt + 1'b1;
                        end
                    end
                end
                LOAD_FEAT: begin
                    if (in_valid && in_ready) begin
                        load_features <= 1'b1;
                        features2     <= in_data;
                        n_feature     <= feat_idx;
                        if (feat_idx == LAST_FEAT) begin
                            feat_idx <= '0;
                            in_ready <= 1'b0;
                            state    <= RUN;
                        end else begin
                            feat_idx <= feat_idx + 32'd2;
                        end
                    end
                end
                RUN: begin
                    // First RUN cycle only raises start, so it lands one cycle
                    // after the last feature write pulse.
                    if (!start) begin
                        start         <= 1'b1;
                        done_low_seen <= 1'b0;
`ifdef FOREST_LOADER_TIMEOUT_EN
                        to_cnt        <= '0;
`endif
                    end else begin
                        if (!done)
                            done_low_seen <= 1'b1;
                        if (done && done_low_seen) begin
                            out_data  <= prediction;
                            start     <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= EMIT;
                        end
`ifdef FOREST_LOADER_TIMEOUT_EN
                        else if (to_cnt == TOW'(TIMEOUT_CYCLES - 1)) begin
                            out_data    <= 32'h8000_0000;
                            timeout_err <= 1'b1;
                            start       <= 1'b0;
                            out_valid   <= 1'b1;
                            state       <= EMIT;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
`endif
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid  <= 1'b0;
                        sample_cnt <= sample_cnt + 16'd1;
                        if (sample_cnt + 16'd1 == n_samples_q) begin
                            state    <= FINISH;
                            job_done <= 1'b1;
                        end else begin
                            state    <= LOAD_FEAT;
                            in_ready <= 1'b1;
                        end
                    end
                end
                FINISH: begin
                    state     <= IDLE;
                    cfg_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_forest_loader.sv
module tb_forest_loader;
    localparam int NT = 16;
    localparam int NN = 256;
    localparam int NF = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid, cfg_load_model, cfg_ready;
    logic [15:0] cfg_n_samples;
    logic        in_valid, in_ready;
    logic [63:0] in_data;
    logic        load_trees;
    logic [3:0]  n_tree;
    logic [7:0]  n_node;
    logic [63:0] tree_nodes;
    logic        load_features;
    logic [31:0] n_feature;
    logic [63:0] features2;
    logic        start, done;
    logic signed [31:0] prediction;
    logic        out_valid, out_ready;
    logic [31:0] out_data;
    logic        job_done;
`ifdef FOREST_LOADER_TIMEOUT_EN
    logic        timeout_err;
`endif

    always #5 clk = ~clk;

    forest_loader #(.N_TREES(NT), .N_NODE_AND_LEAFS(NN), .N_FEATURE(NF), .TIMEOUT_CYCLES(4096)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_load_model(cfg_load_model), .cfg_n_samples(cfg_n_samples),
        .cfg_ready(cfg_ready),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .load_trees(load_trees), .n_tree(n_tree), .n_node(n_node), .tree_nodes(tree_nodes),
        .load_features(load_features), .n_feature(n_feature), .features2(features2),
        .start(start), .done(done), .prediction(prediction),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .job_done(job_done)
`ifdef FOREST_LOADER_TIMEOUT_EN
        , .timeout_err(timeout_err)
`endif
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: expected write/result streams in arrival order.
    typedef struct { logic [3:0] t; logic [7:0] n; logic [63:0] d; } tw_t;
    typedef struct { logic [31:0] k; logic [63:0] d; } fw_t;
    tw_t         tree_q[$];
    fw_t         feat_q[$];
    logic [31:0] pred_q[$];

    typedef struct {
        bit lm; int ns; bit stale; bit bp; bit pack;
        int exp_tw; int exp_fw; int exp_out; int exp_jd;
    } job_t;

    int cyc = 0;
    int tw_cnt, fw_cnt, out_cnt, jd_cnt, start_cnt, cur_ns;
    int first_jd_cyc, cfg_cyc, last_feat_cyc;
    bit stale_mode = 0, bp_mode = 0, mute = 0;

    // Monitor: everything sampled on the falling edge.
    tw_t te; fw_t fe; logic [31:0] pe;
    logic start_d = 0, ov_d = 0, or_d = 0, jd_d = 0, hs_d = 0, hs_now;
    logic [31:0] od_d = 0;
    always @(negedge clk) begin
        cyc++;
        hs_now = 1'b0;
        if (!rst) begin
            if (load_trees) begin
                tw_cnt++;
                if (tree_q.size() == 0) chk("tree_write_unexpected", 1, 0);
                else begin
                    te = tree_q.pop_front();
                    chk("n_tree", n_tree, te.t);
                    chk("n_node", n_node, te.n);
                    chk("tree_nodes", tree_nodes, te.d);
                end
            end
            if (load_features) begin
                fw_cnt++;
                last_feat_cyc = cyc;
                if (feat_q.size() == 0) chk("feat_write_unexpected", 1, 0);
                else begin
                    fe = feat_q.pop_front();
                    chk("n_feature", n_feature, fe.k);
                    chk("features2", features2, fe.d);
                end
            end
            if (start && !start_d) begin
                start_cnt++;
                chk("start_after_last_feat", 64'(cyc - last_feat_cyc), 1);
            end
            if (hs_d) begin
                if (out_cnt < cur_ns) chk("b2b_in_ready", in_ready, 1);
                else                  chk("job_done_after_hs", job_done, 1);
            end
            if (out_valid) begin
                chk("in_ready_in_emit", in_ready, 0);
                if (ov_d && !or_d) chk("out_data_stable", out_data, od_d);
                if (out_ready) begin
                    out_cnt++;
                    hs_now = 1'b1;
                    if (pred_q.size() == 0) chk("output_unexpected", 1, 0);
                    else begin
                        pe = pred_q.pop_front();
                        chk("out_data", out_data, pe);
                    end
                end
            end
            if (jd_d) chk("cfg_ready_after_job_done", cfg_ready, 1);
            if (job_done) begin
                jd_cnt++;
                if (first_jd_cyc < 0) first_jd_cyc = cyc;
            end
        end
        start_d = start; ov_d = out_valid; or_d = out_ready; od_d = out_data;
        jd_d = job_done && !rst; hs_d = hs_now;
    end

    // Forest-engine responder.
    logic [31:0] p;
    initial begin
        done = 0; prediction = 0;
        forever begin
            @(posedge clk); #1;
            if (start && !rst) begin
                if (mute) begin
                    done = 0;
                    while (start) begin @(posedge clk); #1; end
                end else begin
                    if (done) begin
                        // stale done from the previous sample, wrong value
                        prediction = 32'hBAD0_0000 | 32'($urandom_range(0, 255));
                        repeat (2) begin @(posedge clk); #1; end
                    end
                    done = 0;
                    repeat (1 + $urandom_range(0, 3)) begin @(posedge clk); #1; end
                    p = $urandom;
                    prediction = p;
                    done = 1;
                    pred_q.push_back(p);
                    while (start) begin @(posedge clk); #1; end
                    if (stale_mode) prediction = 32'hBAD1_0000 | 32'($urandom_range(0, 255));
                    else            done = 0;
                end
            end
        end
    end

    // Output consumer: random ready, or 10-cycle backpressure per result.
    int bp_cnt = 0;
    initial begin
        out_ready = 0;
        forever begin
            @(posedge clk); #1;
            if (bp_mode) begin
                if (out_valid) begin
                    if (bp_cnt < 10) begin out_ready = 0; bp_cnt++; end
                    else begin out_ready = 1; bp_cnt = 0; end
                end else begin
                    out_ready = 0; bp_cnt = 0;
                end
            end else begin
                out_ready = ($urandom_range(0, 2) != 0);
            end
        end
    end

    task automatic send_word(input logic [63:0] w);
        int  n;
        bit  acc;
        if ($urandom_range(0, 7) == 0) begin
            in_valid = 0; in_data = {$urandom, $urandom};
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
        end
        in_valid = 1; in_data = w;
        // junk job requests while busy must be ignored
        cfg_valid = 1'($urandom_range(0, 1)); cfg_load_model = 1; cfg_n_samples = 16'hFFFF;
        n = 0; acc = 0;
        while (!acc && n < 6000) begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1;
            n++;
        end
        in_valid = 0; cfg_valid = 0; cfg_load_model = 0; cfg_n_samples = 0;
        if (!acc) chk("in_accept_timeout", 0, 1);
    endtask

    task automatic begin_job(input bit lm, input int ns);
        int n = 0;
        while (!cfg_ready && n < 100) begin @(posedge clk); #1; n++; end
        chk("cfg_ready_before_job", cfg_ready, 1);
        tw_cnt = 0; fw_cnt = 0; out_cnt = 0; jd_cnt = 0; start_cnt = 0;
        cur_ns = ns; first_jd_cyc = -1;
        cfg_valid = 1; cfg_load_model = lm; cfg_n_samples = 16'(ns);
        cfg_cyc = cyc + 1;
        @(posedge clk); #1;
        cfg_valid = 0; cfg_load_model = 0; cfg_n_samples = 0;
    endtask

    task automatic send_trees(input int count);
        logic [63:0] w;
        for (int i = 0; i < count; i++) begin
            w = {16'(i / NN), 16'(i % NN), $urandom};
            tree_q.push_back('{4'(i / NN), 8'(i % NN), w});
            send_word(w);
        end
    endtask

    task automatic run_job(input job_t j);
        logic [63:0] w;
        int n;
        stale_mode = j.stale; bp_mode = j.bp;
        begin_job(j.lm, j.ns);
        if (j.lm) send_trees(NT * NN);
        for (int s = 0; s < j.ns; s++)
            for (int k = 0; k < NF / 2; k++) begin
                w = (j.pack && s == 0 && k == 0) ? 64'h0000_0002_0000_0001 : {$urandom, $urandom};
                feat_q.push_back('{32'(2 * k), w});
                send_word(w);
            end
        n = 0;
        while (jd_cnt == 0 && n < 20000) begin @(posedge clk); #1; n++; end
        repeat (3) @(posedge clk);
        #1;
        chk("tree_writes", 64'(tw_cnt), 64'(j.exp_tw));
        chk("feat_writes", 64'(fw_cnt), 64'(j.exp_fw));
        chk("outputs", 64'(out_cnt), 64'(j.exp_out));
        chk("starts", 64'(start_cnt), 64'(j.exp_out));
        chk("job_done_pulses", 64'(jd_cnt), 64'(j.exp_jd));
        chk("pending_results", 64'(pred_q.size()), 0);
        chk("pending_writes", 64'(tree_q.size() + feat_q.size()), 0);
        stale_mode = 0; bp_mode = 0;
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_cfg_ready"}, cfg_ready, 1);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_load_trees"}, load_trees, 0);
        chk({tag, "_n_tree"}, n_tree, 0);
        chk({tag, "_n_node"}, n_node, 0);
        chk({tag, "_tree_nodes"}, tree_nodes, 0);
        chk({tag, "_load_features"}, load_features, 0);
        chk({tag, "_n_feature"}, n_feature, 0);
        chk({tag, "_features2"}, features2, 0);
        chk({tag, "_start"}, start, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_job_done"}, job_done, 0);
    endtask

    job_t jobs[5];
    job_t rj;

    initial begin
        // {lm, ns, stale, bp, pack, tree writes, feat writes, outputs, job_done}
        jobs[0] = '{1, 1, 0, 0, 1, NT * NN, NF / 2, 1, 1};
        jobs[1] = '{0, 3, 0, 1, 0, 0, 3 * NF / 2, 3, 1};
        jobs[2] = '{0, 4, 1, 0, 0, 0, 4 * NF / 2, 4, 1};
        jobs[3] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
        jobs[4] = '{0, 2, 0, 0, 1, 0, NF, 2, 1};

        rst = 1; cfg_valid = 0; cfg_load_model = 0; cfg_n_samples = 0;
        in_valid = 0; in_data = 0;
        repeat (2) @(negedge clk);
        chk_idle_outs("reset");
`ifdef FOREST_LOADER_TIMEOUT_EN
        chk("reset_timeout_err", timeout_err, 0);
`endif
        @(posedge clk); #1;
        rst = 0;

        for (int i = 0; i < 5; i++) begin
            run_job(jobs[i]);
            if (jobs[i].ns == 0)
                chk("zero_job_done_latency_ok", 64'((first_jd_cyc - cfg_cyc) inside {1, 2}), 1);
        end

        // randomized feature-only jobs
        for (int r = 0; r < 6; r++) begin
            rj.lm = 0; rj.ns = $urandom_range(1, 4);
            rj.stale = 1'($urandom_range(0, 1)); rj.bp = ($urandom_range(0, 2) == 0); rj.pack = 0;
            rj.exp_tw = 0; rj.exp_fw = rj.ns * NF / 2; rj.exp_out = rj.ns; rj.exp_jd = 1;
            run_job(rj);
        end

        // reset in the middle of a tree load, then a clean job from node 0
        begin_job(1, 1);
        send_trees(100);
        @(posedge clk); #1;
        rst = 1;
        #1;
        chk_idle_outs("midreset");
        tree_q.delete(); feat_q.delete();
        in_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        run_job('{1, 1, 0, 0, 0, NT * NN, NF / 2, 1, 1});

`ifdef FOREST_LOADER_TIMEOUT_EN
        mute = 1;
        pred_q.push_back(32'h8000_0000);
        run_job('{0, 1, 0, 0, 0, 0, NF / 2, 1, 1});
        chk("timeout_err_set", timeout_err, 1);
        mute = 0;
        run_job('{0, 1, 0, 0, 0, 0, NF / 2, 1, 1});
        chk("timeout_err_cleared", timeout_err, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
